// File: rtl/rr_ctrl_pkg.sv
// rtl/rr_ctrl_pkg.sv - shared state, class and opcode definitions for the rr_ctrl sequencer
package rr_ctrl_pkg;

    // Step number doubles as the state encoding so the step output is the state itself.
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_IDLE = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CLS_R3      = 2'd0,
        CLS_UNARY   = 2'd1,
        CLS_MULDIV  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } cls_e;

    localparam logic [4:0] OPC_ADD = 5'b00011;
    localparam logic [4:0] OPC_SUB = 5'b00100;
    localparam logic [4:0] OPC_AND = 5'b00101;
    localparam logic [4:0] OPC_OR  = 5'b00110;
    localparam logic [4:0] OPC_NEG = 5'b10001;
    localparam logic [4:0] OPC_NOT = 5'b10010;
    localparam logic [4:0] OPC_MUL = 5'b10000;
    localparam logic [4:0] OPC_DIV = 5'b01111;

    function automatic state_e last_step(input cls_e cls);
        state_e s;
        case (cls)
            CLS_R3:     s = ST_T5;
            CLS_UNARY:  s = ST_T4;
            CLS_MULDIV: s = ST_T6;
            default:    s = ST_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/rr_ctrl_decode.sv
// rtl/rr_ctrl_decode.sv - combinational instruction field and class decode
module rr_ctrl_decode
    import rr_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int OPC_W     = 5,
    parameter int INSTR_W   = 32
) (
    input  logic [INSTR_W-1:0]   ir,
    output logic [OPC_W-1:0]     opcode,
    output logic [1:0]           cls,
    output logic [REG_IDX_W-1:0] ra,
    output logic [REG_IDX_W-1:0] rb,
    output logic [REG_IDX_W-1:0] rc,
    output logic                 idx_err
);

    localparam int LOW_W = INSTR_W - OPC_W - 3 * REG_IDX_W;

    cls_e opc_cls;
    logic unused_low_bits;

    assign opcode = ir[INSTR_W-1 -: OPC_W];
    assign ra     = ir[INSTR_W-1-OPC_W -: REG_IDX_W];
    assign rb     = ir[INSTR_W-1-OPC_W-REG_IDX_W -: REG_IDX_W];
    assign rc     = ir[INSTR_W-1-OPC_W-2*REG_IDX_W -: REG_IDX_W];
    assign unused_low_bits = ^ir[LOW_W-1:0];

    always_comb begin
        opc_cls = CLS_ILLEGAL;
        case (opcode)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: opc_cls = CLS_R3;
            OPC_NEG, OPC_NOT:                  opc_cls = CLS_UNARY;
            OPC_MUL, OPC_DIV:                  opc_cls = CLS_MULDIV;
            default:                           opc_cls = CLS_ILLEGAL;
        endcase
    end

    // rc is only an operand for three-register instructions.
    always_comb begin
        idx_err = (32'(ra) >= NUM_REGS) || (32'(rb) >= NUM_REGS)
               || ((opc_cls == CLS_R3) && (32'(rc) >= NUM_REGS));
    end

    assign cls = opc_cls;

endmodule

// File: rtl/rr_ctrl_sequencer.sv
// rtl/rr_ctrl_sequencer.sv - hardwired control-step sequencer for register-register ALU instructions
module rr_ctrl_sequencer
    import rr_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int OPC_W     = 5,
    parameter int INSTR_W   = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [INSTR_W-1:0]  ir,
    output logic                PCout,
    output logic                IncPC,
    output logic                MARin,
    output logic                memRead,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OPC_W-1:0]    alu_op,
    output logic [2:0]          step,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    state_e                 state_q, state_d;
    logic [OPC_W-1:0]       opcode;
    logic [1:0]             cls_bits;
    logic [REG_IDX_W-1:0]   ra, rb, rc;
    logic                   idx_err;
    cls_e                   cls;
    logic                   rout_en, rin_en;
    logic [REG_IDX_W-1:0]   rout_idx, rin_idx;

    rr_ctrl_decode #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W),
        .OPC_W     (OPC_W),
        .INSTR_W   (INSTR_W)
    ) u_decode (
        .ir      (ir),
        .opcode  (opcode),
        .cls     (cls_bits),
        .ra      (ra),
        .rb      (rb),
        .rc      (rc),
        .idx_err (idx_err)
    );

    assign cls = idx_err ? CLS_ILLEGAL : cls_e'(cls_bits);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (mem_ready) state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            default: begin
                // The final step re-samples start so back-to-back instructions need no bubble.
                if (state_q == last_step(cls)) state_d = start ? ST_T0 : ST_IDLE;
                else                           state_d = state_e'(state_q + 3'd1);
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; memRead = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0; done = 1'b0; illegal = 1'b0;
        rout_en = 1'b0; rin_en = 1'b0; rout_idx = '0; rin_idx = '0;
        case (state_q)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            ST_T1: begin memRead = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (cls)
                    CLS_R3:     begin rout_en = 1'b1; rout_idx = rb; Yin = 1'b1; end
                    CLS_UNARY:  begin rout_en = 1'b1; rout_idx = rb; Zin = 1'b1; end
                    CLS_MULDIV: begin rout_en = 1'b1; rout_idx = ra; Yin = 1'b1; end
                    default:    illegal = 1'b1;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_R3:     begin rout_en = 1'b1; rout_idx = rc; Zin = 1'b1; end
                    CLS_UNARY:  begin Zlowout = 1'b1; rin_en = 1'b1; rin_idx = ra; done = 1'b1; end
                    CLS_MULDIV: begin rout_en = 1'b1; rout_idx = rb; Zin = 1'b1; end
                    default:    ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_R3:     begin Zlowout = 1'b1; rin_en = 1'b1; rin_idx = ra; done = 1'b1; end
                    CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default:    ;
                endcase
            end
            ST_T6: begin
                if (cls == CLS_MULDIV) begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
            end
            default: ;
        endcase
        Rout   = rout_en ? (NUM_REGS'(1) << rout_idx) : '0;
        Rin    = rin_en ? (NUM_REGS'(1) << rin_idx) : '0;
        alu_op = Zin ? opcode : '0;
        step   = state_q;
        busy   = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_rr_ctrl_sequencer.sv
// tb/tb_rr_ctrl_sequencer.sv - self-checking bench for rr_ctrl_sequencer
module tb_rr_ctrl_sequencer;

    typedef struct {
        logic [31:0] ir;
        logic        start, mem_ready;
        logic [2:0]  step;
        logic        busy, done, illegal;
        logic        pc_out, inc_pc, mar_in, mem_read, mdr_in, mdr_out, ir_in;
        logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
        logic [15:0] rout, rin;
        logic [4:0]  alu_op;
    } cyc_t;

    logic        clock = 1'b0;
    logic        clear = 1'b1, start = 1'b0, mem_ready = 1'b0;
    logic [31:0] ir = 32'h0;

    logic PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rout, Rin;
    logic [4:0]  alu_op;
    logic [2:0]  step;
    logic        busy, done, illegal;

    logic d_PCout, d_IncPC, d_MARin, d_memRead, d_MDRin, d_MDRout, d_IRin, d_Yin, d_Zin;
    logic d_Zlowout, d_Zhighout, d_HIin, d_LOin;
    logic [11:0] d_Rout, d_Rin;
    logic [4:0]  d_alu_op;
    logic [2:0]  d_step;
    logic        d_busy, d_done, d_illegal;

    int   total = 0, passed = 0;
    cyc_t exp_q[$];

    always #5 clock = ~clock;

    rr_ctrl_sequencer #(.NUM_REGS(16), .REG_IDX_W(4), .OPC_W(5), .INSTR_W(32)) u_dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .memRead(memRead), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin),
        .alu_op(alu_op), .step(step), .busy(busy), .done(done), .illegal(illegal)
    );

    rr_ctrl_sequencer #(.NUM_REGS(12), .REG_IDX_W(4), .OPC_W(5), .INSTR_W(32)) u_dut12 (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .PCout(d_PCout), .IncPC(d_IncPC), .MARin(d_MARin), .memRead(d_memRead), .MDRin(d_MDRin),
        .MDRout(d_MDRout), .IRin(d_IRin), .Yin(d_Yin), .Zin(d_Zin), .Zlowout(d_Zlowout),
        .Zhighout(d_Zhighout), .HIin(d_HIin), .LOin(d_LOin), .Rout(d_Rout), .Rin(d_Rin),
        .alu_op(d_alu_op), .step(d_step), .busy(d_busy), .done(d_done), .illegal(d_illegal)
    );

    function automatic cyc_t blank(input logic [31:0] v, input logic [2:0] st);
        cyc_t c;
        c = '{default: '0};
        c.ir = v;
        c.step = st;
        c.busy = (st != 3'd7);
        c.mem_ready = 1'($urandom);
        return c;
    endfunction

    function automatic logic [55:0] pack(input cyc_t c);
        return {c.step, c.busy, c.done, c.illegal, c.pc_out, c.inc_pc, c.mar_in, c.mem_read,
                c.mdr_in, c.mdr_out, c.ir_in, c.y_in, c.z_in, c.zlo_out, c.zhi_out, c.hi_in,
                c.lo_in, c.rout, c.rin, c.alu_op};
    endfunction

    function automatic void push_idle(input logic s, input logic [31:0] v);
        cyc_t c;
        c = blank(v, 3'd7);
        c.start = s;
        exp_q.push_back(c);
    endfunction

    // Reference: fetch cycles, then the class-specific execute list; start is noise except in the last step.
    function automatic void push_instr(input logic [31:0] v, input int waits, input logic chain,
                                       input logic noise);
        cyc_t c;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        int cls;
        opc = v[31:27]; ra = v[26:23]; rb = v[22:19]; rc = v[18:15];
        if (opc == 5'd3 || opc == 5'd4 || opc == 5'd5 || opc == 5'd6) cls = 0;
        else if (opc == 5'd17 || opc == 5'd18)                       cls = 1;
        else if (opc == 5'd16 || opc == 5'd15)                       cls = 2;
        else                                                         cls = 3;
        c = blank(v, 3'd0); c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.start = noise & 1'($urandom);
        exp_q.push_back(c);
        for (int w = 0; w <= waits; w++) begin
            c = blank(v, 3'd1); c.mem_read = 1; c.mdr_in = 1; c.mem_ready = (w == waits);
            c.start = noise & 1'($urandom);
            exp_q.push_back(c);
        end
        c = blank(v, 3'd2); c.mdr_out = 1; c.ir_in = 1; c.start = noise & 1'($urandom);
        exp_q.push_back(c);
        case (cls)
            0: begin
                c = blank(v, 3'd3); c.rout = 16'(1) << rb; c.y_in = 1; c.start = noise & 1'($urandom);
                exp_q.push_back(c);
                c = blank(v, 3'd4); c.rout = 16'(1) << rc; c.z_in = 1; c.alu_op = opc;
                c.start = noise & 1'($urandom);
                exp_q.push_back(c);
                c = blank(v, 3'd5); c.zlo_out = 1; c.rin = 16'(1) << ra; c.done = 1; c.start = chain;
                exp_q.push_back(c);
            end
            1: begin
                c = blank(v, 3'd3); c.rout = 16'(1) << rb; c.z_in = 1; c.alu_op = opc;
                c.start = noise & 1'($urandom);
                exp_q.push_back(c);
                c = blank(v, 3'd4); c.zlo_out = 1; c.rin = 16'(1) << ra; c.done = 1; c.start = chain;
                exp_q.push_back(c);
            end
            2: begin
                c = blank(v, 3'd3); c.rout = 16'(1) << ra; c.y_in = 1; c.start = noise & 1'($urandom);
                exp_q.push_back(c);
                c = blank(v, 3'd4); c.rout = 16'(1) << rb; c.z_in = 1; c.alu_op = opc;
                c.start = noise & 1'($urandom);
                exp_q.push_back(c);
                c = blank(v, 3'd5); c.zlo_out = 1; c.lo_in = 1; c.start = noise & 1'($urandom);
                exp_q.push_back(c);
                c = blank(v, 3'd6); c.zhi_out = 1; c.hi_in = 1; c.done = 1; c.start = chain;
                exp_q.push_back(c);
            end
            default: begin
                c = blank(v, 3'd3); c.illegal = 1; c.start = chain;
                exp_q.push_back(c);
            end
        endcase
    endfunction

    task automatic step_cycle(input cyc_t c, output logic [55:0] act);
        @(negedge clock);
        start = c.start; mem_ready = c.mem_ready; ir = c.ir;
        #1;
        act = {step, busy, done, illegal, PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, HIin, LOin, Rout, Rin, alu_op};
    endtask

    task automatic test_reset();
        logic [55:0] idle_vec;
        idle_vec = pack(blank(32'h0, 3'd7));
        clear = 1'b1; start = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        total++;
        if ({step, busy, done, illegal, PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin,
             Zlowout, Zhighout, HIin, LOin, Rout, Rin, alu_op} !== idle_vec)
            $display("FAIL reset_idle got=%h exp=%h", {step, busy, done, illegal, PCout, IncPC,
                     MARin, memRead, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                     Rout, Rin, alu_op}, idle_vec);
        else passed++;
        total++;
        if ({d_step, d_busy} !== {3'd7, 1'b0}) $display("FAIL reset_dut12 got=%h exp=%h", {d_step, d_busy}, 4'he);
        else passed++;
        @(negedge clock);
        clear = 1'b0; start = 1'b0;
    endtask

    task automatic test_sub();
        cyc_t c; logic [55:0] act; int n = 0, dones = 0, busy_cyc = 0;
        push_idle(1, 32'h2091_8000); push_instr(32'h2091_8000, 0, 0, 1); push_idle(0, 32'h2091_8000);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL sub cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            dones += int'(done); busy_cyc += int'(busy); n++;
        end
        total++;
        if (dones != 1 || busy_cyc != 6) $display("FAIL sub_len got=%0d/%0d exp=1/6", dones, busy_cyc);
        else passed++;
    endtask

    task automatic test_mem_wait();
        cyc_t c; logic [55:0] act; int n = 0, dones = 0, busy_cyc = 0, t1 = 0;
        push_idle(1, 32'h2091_8000); push_instr(32'h2091_8000, 3, 0, 1); push_idle(0, 32'h2091_8000);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL memwait cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            dones += int'(done); busy_cyc += int'(busy); t1 += int'(memRead & MDRin); n++;
        end
        total++;
        if (dones != 1 || busy_cyc != 9 || t1 != 4)
            $display("FAIL memwait_len got=%0d/%0d/%0d exp=1/9/4", dones, busy_cyc, t1);
        else passed++;
    endtask

    task automatic test_mul();
        cyc_t c; logic [55:0] act; int n = 0, dones = 0, busy_cyc = 0;
        push_idle(1, 32'h8118_0000); push_instr(32'h8118_0000, 1, 0, 1); push_idle(0, 32'h8118_0000);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL mul cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            dones += int'(done); busy_cyc += int'(busy); n++;
        end
        total++;
        if (dones != 1 || busy_cyc != 8) $display("FAIL mul_len got=%0d/%0d exp=1/8", dones, busy_cyc);
        else passed++;
    endtask

    task automatic test_unary();
        cyc_t c; logic [55:0] act; int n = 0, busy_cyc = 0;
        logic [31:0] v;
        v = {5'b10010, 4'd5, 4'd7, 4'd0, 15'h1234};
        push_idle(1, v); push_instr(v, 0, 0, 1); push_idle(0, v);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL unary cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            busy_cyc += int'(busy); n++;
        end
        total++;
        if (busy_cyc != 5) $display("FAIL unary_len got=%0d exp=5", busy_cyc);
        else passed++;
    endtask

    task automatic test_illegal();
        cyc_t c; logic [55:0] act; int n = 0, ill = 0, bad = 0;
        push_idle(1, 32'hF800_0000); push_instr(32'hF800_0000, 0, 0, 1); push_idle(0, 32'hF800_0000);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL illegal cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            ill += int'(illegal); bad += int'(done | Zin | (|Rin)); n++;
        end
        total++;
        if (ill != 1 || bad != 0 || step !== 3'd7)
            $display("FAIL illegal_summary got=%0d/%0d/%0d exp=1/0/7", ill, bad, step);
        else passed++;
    endtask

    task automatic test_idx_err();
        cyc_t c; logic [55:0] act; int n = 0, ill = 0, bad = 0;
        clear = 1'b1; @(negedge clock); clear = 1'b0;
        push_idle(1, 32'h1E00_0000); push_instr(32'h1E00_0000, 0, 0, 0); push_idle(0, 32'h1E00_0000);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL idx16 cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            if (c.step == 3'd3) begin
                total++;
                if (d_illegal !== 1'b1 || d_Rout !== 12'h0 || d_Yin !== 1'b0)
                    $display("FAIL idx12_t3 got=%b/%h/%b exp=1/000/0", d_illegal, d_Rout, d_Yin);
                else passed++;
            end
            ill += int'(d_illegal); bad += int'(d_done | (|d_Rin)); n++;
        end
        total++;
        if (ill != 1 || bad != 0 || d_step !== 3'd7)
            $display("FAIL idx12_summary got=%0d/%0d/%0d exp=1/0/7", ill, bad, d_step);
        else passed++;
    endtask

    task automatic test_clear_mid();
        cyc_t c; logic [55:0] act; int n = 0, rin_seen = 0; logic hit = 1'b0;
        push_idle(1, 32'h2091_8000); push_instr(32'h2091_8000, 0, 0, 1);
        while (exp_q.size() > 0 && !hit) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL clrmid cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            rin_seen += int'(|Rin); hit = (c.step == 3'd4); n++;
        end
        exp_q.delete();
        clear = 1'b1; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            clear = 1'b0; start = 1'b0;
            act = {step, busy, done, illegal, PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
                   Yin, Zin, Zlowout, Zhighout, HIin, LOin, Rout, Rin, alu_op};
            total++;
            if (act !== pack(blank(32'h0, 3'd7))) $display("FAIL clrmid_idle%0d got=%h", k, act);
            else passed++;
            rin_seen += int'(|Rin);
        end
        total++;
        if (rin_seen != 0 || !hit) $display("FAIL clrmid_rin got=%0d/%b exp=0/1", rin_seen, hit);
        else passed++;
    endtask

    task automatic test_back_to_back();
        cyc_t c; logic [55:0] act; int n = 0, d0 = -1, d1 = -1;
        push_idle(1, 32'h2091_8000); push_instr(32'h2091_8000, 0, 1, 1);
        push_instr(32'h2091_8000, 0, 0, 1); push_idle(0, 32'h2091_8000);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL b2b cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            if (done) begin if (d0 < 0) d0 = n; else d1 = n; end
            n++;
        end
        total++;
        if (d0 < 0 || d1 - d0 != 6) $display("FAIL b2b_gap got=%0d exp=6", d1 - d0);
        else passed++;
    endtask

    task automatic test_random();
        cyc_t c; logic [55:0] act; int n = 0; logic prev_chain = 1'b0, chain;
        logic [4:0] opc; logic [31:0] v;
        logic [4:0] legal [8];
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd17, 5'd18, 5'd16, 5'd15};
        v = 32'h0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) opc = 5'($urandom_range(19, 31));
            else                          opc = legal[$urandom_range(0, 7)];
            v = {opc, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
            chain = (i == 23) ? 1'b0 : 1'($urandom);
            if (!prev_chain) push_idle(1, v);
            push_instr(v, $urandom_range(0, 3), chain, 1);
            prev_chain = chain;
        end
        push_idle(0, v);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front(); step_cycle(c, act); total++;
            if (act !== pack(c)) $display("FAIL random cyc%0d got=%h exp=%h", n, act, pack(c));
            else passed++;
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sub();
        test_mem_wait();
        test_mul();
        test_unary();
        test_illegal();
        test_idx_err();
        test_clear_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
